// File: rtl/axi_full_slave_mem.sv
// AXI4-full slave backed by an on-chip word array; one outstanding burst per direction.
// Define SAXI_WLAST_CHECK_EN to answer SLVERR when WLAST is not asserted exactly on the final beat.
module axi_full_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH     = 1,
    parameter int C_S_AXI_DATA_WIDTH   = 128,
    parameter int C_S_AXI_ADDR_WIDTH   = 32,
    parameter int C_S_AXI_AWUSER_WIDTH = 1,
    parameter int C_S_AXI_ARUSER_WIDTH = 1,
    parameter int C_S_AXI_WUSER_WIDTH  = 1,
    parameter int C_S_AXI_RUSER_WIDTH  = 1,
    parameter int C_S_AXI_BUSER_WIDTH  = 1,
    parameter int MEM_WORDS_LOG2       = 18
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [7:0]                        S_AXI_AWLEN,
    input  logic [2:0]                        S_AXI_AWSIZE,
    input  logic [1:0]                        S_AXI_AWBURST,
    input  logic                              S_AXI_AWLOCK,
    input  logic [3:0]                        S_AXI_AWCACHE,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic [3:0]                        S_AXI_AWQOS,
    input  logic [3:0]                        S_AXI_AWREGION,
    input  logic [C_S_AXI_AWUSER_WIDTH-1:0]   S_AXI_AWUSER,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WLAST,
    input  logic [C_S_AXI_WUSER_WIDTH-1:0]    S_AXI_WUSER,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_BID,
    output logic [1:0]                        S_AXI_BRESP,
    output logic [C_S_AXI_BUSER_WIDTH-1:0]    S_AXI_BUSER,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [7:0]                        S_AXI_ARLEN,
    input  logic [2:0]                        S_AXI_ARSIZE,
    input  logic [1:0]                        S_AXI_ARBURST,
    input  logic                              S_AXI_ARLOCK,
    input  logic [3:0]                        S_AXI_ARCACHE,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic [3:0]                        S_AXI_ARQOS,
    input  logic [3:0]                        S_AXI_ARREGION,
    input  logic [C_S_AXI_ARUSER_WIDTH-1:0]   S_AXI_ARUSER,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]       S_AXI_RID,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RLAST,
    output logic [C_S_AXI_RUSER_WIDTH-1:0]    S_AXI_RUSER,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int STRB_W   = DW / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int DEPTH    = 1 << MEM_WORDS_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    // Address of the following beat; WRAP keeps the bits above the block boundary fixed
    function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step;
        logic [AW-1:0] mask;
        logic [AW-1:0] incr;
        step = AW'(1) << size;
        incr = (addr & ~(step - AW'(1))) + step;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            2'b00:   f_next_addr = addr;
            2'b10:   f_next_addr = (addr & ~mask) | (incr & mask);
            default: f_next_addr = incr;
        endcase
    endfunction

    logic [DW-1:0] r_mem [0:DEPTH-1];

    wstate_t                       r_wstate;
    wstate_t                       w_wstate_nxt;
    logic                          r_awready;
    logic                          r_wready;
    logic                          r_bvalid;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_bid;
    logic [1:0]                    r_bresp;
    logic [AW-1:0]                 r_waddr;
    logic [7:0]                    r_wlen;
    logic [2:0]                    r_wsize;
    logic [1:0]                    r_wburst;
    logic [7:0]                    r_wcnt;
    logic                          r_wlast_err;
    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_b_hs;
    logic                          w_wlast_beat;
    logic                          w_wlast_bad;
    logic [MEM_WORDS_LOG2-1:0]     w_widx;

    rstate_t                       r_rstate;
    rstate_t                       w_rstate_nxt;
    logic                          r_arready;
    logic                          r_rvalid;
    logic                          r_rlast;
    logic [DW-1:0]                 r_rdata;
    logic [C_S_AXI_ID_WIDTH-1:0]   r_rid;
    logic [AW-1:0]                 r_raddr;
    logic [7:0]                    r_rlen;
    logic [2:0]                    r_rsize;
    logic [1:0]                    r_rburst;
    logic [7:0]                    r_rcnt;
    logic                          w_ar_hs;
    logic                          w_r_hs;
    logic                          w_rlast_beat;
    logic [MEM_WORDS_LOG2-1:0]     w_ar_idx;
    logic [MEM_WORDS_LOG2-1:0]     w_ridx;
    logic                          w_unused_ok;

    assign w_aw_hs      = S_AXI_AWVALID & r_awready;
    assign w_w_hs       = S_AXI_WVALID & r_wready;
    assign w_b_hs       = r_bvalid & S_AXI_BREADY;
    assign w_wlast_beat = (r_wcnt == r_wlen);
    assign w_widx       = r_waddr[ADDR_LSB +: MEM_WORDS_LOG2];
    assign w_ar_hs      = S_AXI_ARVALID & r_arready;
    assign w_r_hs       = r_rvalid & S_AXI_RREADY;
    assign w_rlast_beat = (r_rcnt == r_rlen);
    assign w_ar_idx     = S_AXI_ARADDR[ADDR_LSB +: MEM_WORDS_LOG2];
    assign w_ridx       = r_raddr[ADDR_LSB +: MEM_WORDS_LOG2];

`ifdef SAXI_WLAST_CHECK_EN
    assign w_wlast_bad = (S_AXI_WLAST != w_wlast_beat);
    assign w_unused_ok = &{1'b0, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                           S_AXI_AWUSER, S_AXI_WUSER, S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT,
                           S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};
`else
    assign w_wlast_bad = 1'b0;
    assign w_unused_ok = &{1'b0, S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                           S_AXI_AWUSER, S_AXI_WUSER, S_AXI_WLAST, S_AXI_ARLOCK, S_AXI_ARCACHE,
                           S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER, w_wlast_bad};
`endif

    // Write engine state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // Write engine next state: burst ends on the counted beat, not on WLAST
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs) w_wstate_nxt = W_DATA;
                else         w_wstate_nxt = W_IDLE;
            end
            W_DATA: begin
                if (w_w_hs && w_wlast_beat) w_wstate_nxt = W_RESP;
                else                        w_wstate_nxt = W_DATA;
            end
            W_RESP: begin
                if (w_b_hs) w_wstate_nxt = W_IDLE;
                else        w_wstate_nxt = W_RESP;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write engine handshake outputs, burst context and response
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= 2'b00;
            r_waddr     <= '0;
            r_wlen      <= 8'd0;
            r_wsize     <= 3'd0;
            r_wburst    <= 2'b00;
            r_wcnt      <= 8'd0;
            r_wlast_err <= 1'b0;
        end else begin
            r_awready <= (r_wstate == W_IDLE) && S_AXI_AWVALID && !r_awready;
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_bid       <= S_AXI_AWID;
                r_waddr     <= S_AXI_AWADDR;
                r_wlen      <= S_AXI_AWLEN;
                r_wsize     <= S_AXI_AWSIZE;
                r_wburst    <= S_AXI_AWBURST;
                r_wcnt      <= 8'd0;
                r_wlast_err <= 1'b0;
            end else if (w_w_hs) begin
                r_waddr     <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
                r_wcnt      <= r_wcnt + 8'd1;
                r_wlast_err <= r_wlast_err | w_wlast_bad;
                if (w_wlast_beat) begin
                    r_bresp <= (r_wlast_err | w_wlast_bad) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    // Byte-strobed memory write; the array itself is never reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_w_hs) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (S_AXI_WSTRB[i]) r_mem[w_widx][i*8 +: 8] <= S_AXI_WDATA[i*8 +: 8];
            end
        end
    end

    // Read engine state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_rstate <= R_IDLE;
        end else begin
            r_rstate <= w_rstate_nxt;
        end
    end

    // Read engine next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_hs) w_rstate_nxt = R_DATA;
                else         w_rstate_nxt = R_IDLE;
            end
            R_DATA: begin
                if (w_r_hs && w_rlast_beat) w_rstate_nxt = R_IDLE;
                else                        w_rstate_nxt = R_DATA;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read datapath: r_raddr always points at the beat after the one on RDATA, so beats stream 1/cycle
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= 8'd0;
            r_rsize   <= 3'd0;
            r_rburst  <= 2'b00;
            r_rcnt    <= 8'd0;
        end else begin
            r_arready <= (r_rstate == R_IDLE) && S_AXI_ARVALID && !r_arready;
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rdata  <= r_mem[w_ar_idx];
                r_rid    <= S_AXI_ARID;
                r_raddr  <= f_next_addr(S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
                r_rlen   <= S_AXI_ARLEN;
                r_rsize  <= S_AXI_ARSIZE;
                r_rburst <= S_AXI_ARBURST;
                r_rcnt   <= 8'd0;
                r_rlast  <= (S_AXI_ARLEN == 8'd0);
            end else if (w_r_hs && !w_rlast_beat) begin
                r_rdata <= r_mem[w_ridx];
                r_raddr <= f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BID     = r_bid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_BUSER   = '0;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RLAST   = r_rlast;
    assign S_AXI_RID     = r_rid;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RUSER   = '0;

endmodule

// File: tb/tb_axi_full_slave_mem.sv
// Scoreboard bench for axi_full_slave_mem: expected read beats are queued per test and
// popped as R beats arrive. Define SAXI_WLAST_CHECK_EN to expect SLVERR in test_wlast.
module tb_axi_full_slave_mem;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [0:0]   awid, bid, arid, rid;
    logic [31:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst, bresp, rresp;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic [127:0] wdata, rdata;
    logic [15:0]  wstrb;
    logic [0:0]   buser, ruser;

    int           n_pass  = 0;
    int           n_total = 0;
    logic [127:0] exp_q[$];
    logic [127:0] wdat[256];
    logic [15:0]  wstb[256];

    always #5 clk = ~clk;

    axi_full_slave_mem dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWID(awid), .S_AXI_AWADDR(awaddr), .S_AXI_AWLEN(awlen), .S_AXI_AWSIZE(awsize),
        .S_AXI_AWBURST(awburst), .S_AXI_AWLOCK(1'b0), .S_AXI_AWCACHE(4'd0), .S_AXI_AWPROT(3'd0),
        .S_AXI_AWQOS(4'd0), .S_AXI_AWREGION(4'd0), .S_AXI_AWUSER(1'b0), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WLAST(wlast), .S_AXI_WUSER(1'b0),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BID(bid), .S_AXI_BRESP(bresp), .S_AXI_BUSER(buser), .S_AXI_BVALID(bvalid),
        .S_AXI_BREADY(bready),
        .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize),
        .S_AXI_ARBURST(arburst), .S_AXI_ARLOCK(1'b0), .S_AXI_ARCACHE(4'd0), .S_AXI_ARPROT(3'd0),
        .S_AXI_ARQOS(4'd0), .S_AXI_ARREGION(4'd0), .S_AXI_ARUSER(1'b0), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RID(rid), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RLAST(rlast),
        .S_AXI_RUSER(ruser), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
    );

    // Full write burst from wdat/wstb; WLAST is driven on beat last_at
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [0:0] id, input int last_at, input logic [1:0] exp_resp);
        int n;
        @(posedge clk); #1;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd4; awburst = burst; awvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!awready && n < 20) begin @(negedge clk); n++; end
        n_total++;
        if (!awready) begin
            $display("FAIL aw_handshake: awready=%0b required 1 within 20 cycles", awready);
            awvalid = 1'b0;
            return;
        end
        n_pass++;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            wdata = wdat[k]; wstrb = wstb[k]; wlast = (k == last_at); wvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!wready && n < 20) begin @(negedge clk); n++; end
            if (!wready) begin
                n_total++;
                $display("FAIL w_handshake: beat %0d wready=%0b required 1", k, wready);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        n_total++;
        if ({bvalid, wready} !== 2'b10) $display("FAIL b_timing: bvalid,wready=%b required 10", {bvalid, wready});
        else n_pass++;
        n_total++;
        if (bresp !== exp_resp) $display("FAIL bresp: got %b required %b", bresp, exp_resp);
        else n_pass++;
        n_total++;
        if (bid !== id) $display("FAIL bid: got %b required %b", bid, id);
        else n_pass++;
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        n_total++;
        if (bvalid !== 1'b0) $display("FAIL b_release: bvalid=%b required 0", bvalid);
        else n_pass++;
    endtask

    // Read burst, comparing each beat against the scoreboard; toggle stalls RREADY every other cycle
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [0:0] id, input bit toggle);
        int           n;
        int           k;
        int           cyc;
        bit           stalled;
        logic [127:0] held;
        logic [127:0] exp_v;
        @(posedge clk); #1;
        arid = id; araddr = addr; arlen = len; arsize = 3'd4; arburst = burst; arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin @(negedge clk); n++; end
        n_total++;
        if (!arready) begin
            $display("FAIL ar_handshake: arready=%0b required 1 within 20 cycles", arready);
            arvalid = 1'b0;
            return;
        end
        n_pass++;
        @(posedge clk); #1;
        arvalid = 1'b0;
        k = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (k <= int'(len) && cyc < 600) begin
            @(negedge clk);
            cyc++;
            rready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (rvalid) begin
                if (stalled) begin
                    n_total++;
                    if (rdata !== held) $display("FAIL r_stable: beat %0d rdata=%h required %h", k, rdata, held);
                    else n_pass++;
                end
                if (rready) begin
                    exp_v = exp_q.pop_front();
                    n_total++;
                    if (rdata !== exp_v) $display("FAIL rdata: beat %0d got %h required %h", k, rdata, exp_v);
                    else n_pass++;
                    n_total++;
                    if (rlast !== (k == int'(len)) || rid !== id)
                        $display("FAIL rlast_rid: beat %0d rlast=%b rid=%b required %b %b", k, rlast, rid,
                                 (k == int'(len)), id);
                    else n_pass++;
                    k++;
                    stalled = 1'b0;
                end else begin
                    held = rdata;
                    stalled = 1'b1;
                end
            end
        end
        if (k <= int'(len)) begin
            n_total++;
            $display("FAIL r_timeout: %0d beats received required %0d", k, int'(len) + 1);
        end
        @(posedge clk); #1;
        rready = 1'b0;
        n_total++;
        if (rvalid !== 1'b0) $display("FAIL r_done: rvalid=%b required 0", rvalid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        awvalid = 1'b1; arvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd4; awburst = 2'b01;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd4; arburst = 2'b01;
        wdata = '0; wstrb = '0; wlast = 1'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b00000)
            $display("FAIL reset_outputs: aw,w,b,ar,r=%b required 00000", {awready, wready, bvalid, arready, rvalid});
        else n_pass++;
        awvalid = 1'b0; arvalid = 1'b0; wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b00000)
            $display("FAIL idle_outputs: aw,w,b,ar,r=%b required 00000", {awready, wready, bvalid, arready, rvalid});
        else n_pass++;
    endtask

    task automatic test_incr();
        for (int k = 0; k < 16; k++) begin wdat[k] = 128'(k); wstb[k] = 16'hFFFF; end
        axi_write(32'h1000_0000, 8'd15, 2'b01, 1'b1, 15, 2'b00);
        for (int k = 0; k < 16; k++) exp_q.push_back(128'(k));
        axi_read(32'h1000_0000, 8'd15, 2'b01, 1'b1, 1'b0);
    endtask

    task automatic test_strobe();
        wdat[0] = {128{1'b1}}; wstb[0] = 16'hFFFF;
        axi_write(32'h0000_0200, 8'd0, 2'b01, 1'b0, 0, 2'b00);
        wdat[0] = '0; wstb[0] = 16'h0001;
        axi_write(32'h0000_0200, 8'd0, 2'b01, 1'b0, 0, 2'b00);
        exp_q.push_back({{120{1'b1}}, 8'h00});
        axi_read(32'h0000_0200, 8'd0, 2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 4; k++) exp_q.push_back(128'(k));
        axi_read(32'h1000_0000, 8'd3, 2'b01, 1'b1, 1'b1);
    endtask

    task automatic test_wrap_fixed();
        wdat[0] = 128'hA; wdat[1] = 128'hB; wdat[2] = 128'hC; wdat[3] = 128'hD;
        for (int k = 0; k < 4; k++) wstb[k] = 16'hFFFF;
        axi_write(32'h0000_0020, 8'd3, 2'b10, 1'b0, 3, 2'b00);
        exp_q.push_back(128'hC); exp_q.push_back(128'hD); exp_q.push_back(128'hA); exp_q.push_back(128'hB);
        axi_read(32'h0000_0000, 8'd3, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) wdat[k] = 128'hE0 + 128'(k);
        axi_write(32'h0000_0040, 8'd3, 2'b00, 1'b1, 3, 2'b00);
        exp_q.push_back(128'hE3); exp_q.push_back(128'hE3);
        axi_read(32'h0000_0040, 8'd1, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic test_wlast();
        logic [1:0] exp_resp;
`ifdef SAXI_WLAST_CHECK_EN
        exp_resp = 2'b10;
`else
        exp_resp = 2'b00;
`endif
        for (int k = 0; k < 4; k++) begin wdat[k] = 128'h5500 + 128'(k); wstb[k] = 16'hFFFF; end
        axi_write(32'h0000_0100, 8'd3, 2'b01, 1'b1, 2, exp_resp);
        for (int k = 0; k < 4; k++) exp_q.push_back(128'h5500 + 128'(k));
        axi_read(32'h0000_0100, 8'd3, 2'b01, 1'b1, 1'b0);
    endtask

    // 256-beat burst starting 128 words below the top of memory rolls over into word 0
    task automatic test_long_rollover();
        for (int k = 0; k < 256; k++) begin wdat[k] = {32'hC0DE_0000, 96'(k)}; wstb[k] = 16'hFFFF; end
        axi_write(32'h003F_F800, 8'd255, 2'b01, 1'b0, 255, 2'b00);
        for (int k = 0; k < 256; k++) exp_q.push_back({32'hC0DE_0000, 96'(k)});
        axi_read(32'h003F_F800, 8'd255, 2'b01, 1'b0, 1'b0);
        exp_q.push_back({32'hC0DE_0000, 96'd128});
        axi_read(32'h0000_0000, 8'd0, 2'b01, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_incr();
        test_strobe();
        test_backpressure();
        test_wrap_fixed();
        test_wlast();
        test_long_rollover();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
